fir_tap_reader: RTL
===================

Name: fir_tap_reader

Overview:
- Read-side sequencer for the FIR sample delay line (shift_register, SIZE taps of WIDTH bits).
- After the delay line shifts in a new sample, the block walks tap addresses 0..SIZE-1 and fetches each tap combinationally from the delay line.
- It streams the taps to the MAC datapath over a valid/ready interface, and marks the final tap and the end of the burst.

Parameters:
- SIZE, 10, number of taps in the delay line.
- WIDTH, 8, sample width in bits.
- ADDR_W, 4, tap address width; must satisfy 2^ADDR_W >= SIZE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; returns the block to IDLE immediately.
- start  input  1  request one burst of SIZE taps; sampled only in IDLE.
- tap_addr  output  ADDR_W  tap index driven to the delay line read mux.
- tap_data  input  WIDTH  delay line tap at tap_addr, valid in the same cycle (combinational read).
- out_data  output  WIDTH  registered tap value to the MAC.
- out_valid  output  1  out_data holds a tap.
- out_ready  input  1  MAC accepts out_data this cycle.
- out_last  output  1  current out_data is tap SIZE-1.
- busy  output  1  burst in progress; the controller must hold the delay line's shift_en low while busy=1.
- done  output  1  one-cycle pulse when the last tap is accepted.

Behaviour:
- States:
  - IDLE: busy=0.
  - SEND: busy=1. busy is decoded from state (busy = state!=IDLE).
- Reset (async, while rst=1):
  - state=IDLE, idx=0, tap_addr=0.
  - out_data=0, out_valid=0, out_last=0, done=0.
- tap_addr equals the internal idx register: 0 in IDLE, otherwise the index of the next tap to load.
- IDLE with start=1 at an edge:
  - out_data<=tap_data (tap 0), out_valid<=1, out_last<=(SIZE==1).
  - idx<=1, state<=SEND.
- IDLE with start=0: hold. done is cleared to 0 every edge unless set by the last-handshake rule.
- A handshake is out_valid && out_ready at an edge.
- SEND, handshake with out_last=0:
  - out_data<=tap_data at tap_addr=idx, out_last<=(idx==SIZE-1), idx<=idx+1.
  - out_valid stays 1.
- SEND, handshake with out_last=1:
  - out_valid<=0, out_last<=0, done<=1 for exactly one cycle.
  - idx<=0, state<=IDLE.
  - out_data holds its last value.
- SEND, no handshake: out_data, out_last, out_valid and idx all hold (backpressure of any length). out_valid never drops before the handshake.
- Throughput and latency, with out_ready held high:
  - one tap per cycle;
  - out_valid is high from the start edge for exactly SIZE cycles;
  - done pulses in the cycle after the last handshake edge.
- start while busy=1 is ignored; no queuing.
- start during the done cycle is accepted, because state is already IDLE. The next burst begins at that edge, with no dead cycle beyond done.
- idx never exceeds SIZE-1 on tap_addr, so there is no wrap-around. Addresses SIZE..2^ADDR_W-1 are never driven.
- Reset mid-burst: the burst is abandoned immediately, with no done pulse. A fresh start after reset restarts at tap 0.
- Arithmetic: idx is an unsigned ADDR_W-bit counter. tap_data passes to out_data unmodified, with no sign handling.

Test Plan:
(SIZE=10, WIDTH=8. The bench delay-line model returns tap_data = 22+tap_addr.)
- Reset value check: rst=1 for 3 ns mid-cycle -> all outputs 0 immediately, with no clock edge needed; tap_addr=0.
- Full-rate burst: start for one cycle, out_ready=1 -> out_data sequence 22..31 on 10 consecutive cycles. out_last is high only with 31. done pulses one cycle after the 31 handshake. busy is high for exactly 10 cycles.
- Backpressure: out_ready=0 for 4 cycles while out_data=25 -> out_data stays 25, out_valid stays 1, tap_addr stays 4. After ready returns, the sequence continues 26..31 with no skip or duplicate.
- Ignored start: pulse start at the 3rd and 7th cycles of a burst -> the burst is unchanged, there is exactly one done, and no second burst.
- Back-to-back: assert start during the done cycle -> a new burst begins at that edge with out_data=22, and busy rises the same edge.
- Reset mid-burst: assert rst after tap 24 is accepted -> outputs clear, no done pulse. A following start yields 22..31 again.

Source files
------------

// File: rtl/fir_tap_reader.sv
// Read-side sequencer for the FIR delay line: walks taps 0..SIZE-1
// and streams them to the MAC over a valid/ready handshake.
module fir_tap_reader #(
    parameter int SIZE   = 10,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] tap_addr,
    input  logic [WIDTH-1:0]  tap_data,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;
    logic              hs;

    assign hs       = out_valid && out_ready;
    assign tap_addr = idx;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        out_data  <= tap_data;
                        out_valid <= 1'b1;
                        out_last  <= (LAST == '0);
                        idx       <= (LAST == '0) ? '0 : ADDR_W'(1);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            idx       <= '0;
                            state     <= IDLE;
                        end else begin
                            out_data <= tap_data;
                            out_last <= (idx == LAST);
                            // Saturate so tap_addr never leaves 0..SIZE-1
                            if (idx != LAST) begin
                                idx <= idx + ADDR_W'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
